apb_clint: RTL and testbench

- APB3/APB4 completer holding a CLINT-style machine timer (64-bit mtime, mtimecmp) and a software interrupt bit.
- Sits directly downstream of the APB delay stage and consumes its out_* bus.
- Drives mtip/msip to the CPU interrupt inputs.
- Supports configurable completer wait states, so the upstream delay logic and wait-state handling both get exercised.

---
 rtl/clint_pkg.sv | 38 +++
 rtl/clint_timer.sv | 53 +++++
 rtl/apb_clint.sv | 109 ++++++++++
 tb/tb_apb_clint.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared offsets, reset values, bus payload types and byte-strobe helper for the APB CLINT.
package clint_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned OFF_W      = 16;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned MTIME_W    = 64;

    localparam logic [OFF_W-1:0] CLINT_MSIP        = 16'h0000;
    localparam logic [OFF_W-1:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [OFF_W-1:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [OFF_W-1:0] CLINT_PRESCALE    = 16'h8000;
    localparam logic [OFF_W-1:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [OFF_W-1:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Software write into one half of mtime; a write replaces that half outright.
    typedef struct packed {
        logic              we_lo;
        logic              we_hi;
        logic [DATA_W-1:0] data;
    } mtime_wr_t;

    // Replace the bytes of old selected by strb with the matching bytes of wdata.
    function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit machine timer with software override and registered compare interrupt.
module clint_timer
    import clint_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  prescale_clr,
    input  mtime_wr_t             mtime_wr,
    input  logic [MTIME_W-1:0]    mtimecmp,
    output logic [MTIME_W-1:0]    mtime,
    output logic                  mtip
);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick;

    assign tick = (pcnt == prescale);

    // Prescale counter: wraps on tick, restarts whenever PRESCALE is rewritten.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (prescale_clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

    // mtime: a software write to either half suppresses that cycle's increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (mtime_wr.we_lo) begin
            mtime <= {mtime[MTIME_W-1:32], mtime_wr.data};
        end else if (mtime_wr.we_hi) begin
            mtime <= {mtime_wr.data, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + MTIME_W'(1);
        end
    end

    // Level timer interrupt from the current register values, one cycle late.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/apb_clint.sv
// APB completer for a CLINT-style machine timer and software interrupt, with wait states.
module apb_clint
    import clint_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_BITS   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [2:0]        in_pprot,
    input  logic              in_pwrite,
    input  logic [DATA_W-1:0] in_pwdata,
    input  logic [STRB_W-1:0] in_pstrb,
    output logic              in_pready,
    output logic [DATA_W-1:0] in_prdata,
    output logic              in_pslverr,
    output logic              mtip,
    output logic              msip
);

    localparam int unsigned DEC_BITS  = (ADDR_BITS < OFF_W) ? ADDR_BITS : OFF_W;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    logic [3:0]            wcnt;
    logic                  access;
    logic [OFF_W-1:0]      off;
    logic                  hit;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     merged;
    logic                  wr_en;
    logic [MTIME_W-1:0]    mtimecmp;
    logic [MTIME_W-1:0]    mtime;
    logic [PRESCALE_W-1:0] prescale;
    mtime_wr_t             mtime_wr;
    logic                  unused_bits;

    assign unused_bits = ^{in_pprot, in_paddr[31:DEC_BITS], in_paddr[1:0]};

    assign off       = OFF_W'({in_paddr[DEC_BITS-1:2], 2'b00});
    assign access    = in_psel & in_penable;
    assign in_pready = access & (wcnt == WAIT_LAST);
    assign wr_en     = in_pready & in_pwrite & hit;
    assign merged    = apply_strb(rdata, in_pwdata, in_pstrb);

    assign in_prdata  = in_pready ? rdata : '0;
    assign in_pslverr = in_pready & ~hit;

    // Wait-state counter: runs through the access phase, clears on completion or deselect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
        end else if (!in_psel || in_pready) begin
            wcnt <= '0;
        end else if (access) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Offset decode and current value of the addressed register.
    always_comb begin
        hit   = 1'b0;
        rdata = '0;
        case (off)
            CLINT_MSIP:        begin hit = 1'b1; rdata = {31'b0, msip};             end
            CLINT_MTIMECMP_LO: begin hit = 1'b1; rdata = mtimecmp[31:0];            end
            CLINT_MTIMECMP_HI: begin hit = 1'b1; rdata = mtimecmp[63:32];           end
            CLINT_PRESCALE:    begin hit = 1'b1; rdata = {16'b0, prescale};         end
            CLINT_MTIME_LO:    begin hit = 1'b1; rdata = mtime[31:0];               end
            CLINT_MTIME_HI:    begin hit = 1'b1; rdata = mtime[63:32];              end
            default:           begin hit = 1'b0; rdata = '0;                        end
        endcase
    end

    // Control registers owned by the APB side; commit on the completing edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip     <= 1'b0;
            mtimecmp <= MTIMECMP_RST;
            prescale <= '0;
        end else if (wr_en) begin
            case (off)
                CLINT_MSIP:        msip            <= merged[0];
                CLINT_MTIMECMP_LO: mtimecmp[31:0]  <= merged;
                CLINT_MTIMECMP_HI: mtimecmp[63:32] <= merged;
                CLINT_PRESCALE:    prescale        <= merged[PRESCALE_W-1:0];
                default:           ;
            endcase
        end
    end

    assign mtime_wr.we_lo = wr_en & (off == CLINT_MTIME_LO);
    assign mtime_wr.we_hi = wr_en & (off == CLINT_MTIME_HI);
    assign mtime_wr.data  = merged;

    clint_timer u_timer (
        .clock        (clock),
        .reset        (reset),
        .prescale     (prescale),
        .prescale_clr (wr_en & (off == CLINT_PRESCALE)),
        .mtime_wr     (mtime_wr),
        .mtimecmp     (mtimecmp),
        .mtime        (mtime),
        .mtip         (mtip)
    );

endmodule

// File: tb/tb_apb_clint.sv
// Randomized self-checking bench for apb_clint against a register-level reference model.
module tb_apb_clint;

    localparam int unsigned WAIT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [2:0]  pprot = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        mtip;
    logic        msip;

    // Bench-owned expectation: this access cycle must complete.
    logic        exp_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [63:0] m_mtime = '0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_msip  = 1'b0;
    logic [15:0] m_pre   = '0;
    int unsigned m_pcnt  = 0;
    logic        m_mtip  = 1'b0;

    apb_clint #(.WAIT_CYCLES(WAIT), .ADDR_BITS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (paddr),
        .in_psel    (psel),
        .in_penable (penable),
        .in_pprot   (pprot),
        .in_pwrite  (pwrite),
        .in_pwdata  (pwdata),
        .in_pstrb   (pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .mtip       (mtip),
        .msip       (msip)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input logic [31:0] act, input int unsigned lo,
                             input int unsigned hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // What a read of this address must return according to the register map.
    function automatic void mread(input logic [31:0] a, output logic [31:0] d, output logic e);
        logic [15:0] o;
        o = {a[15:2], 2'b00};
        e = 1'b0;
        case (o)
            16'h0000: d = {31'b0, m_msip};
            16'h4000: d = m_cmp[31:0];
            16'h4004: d = m_cmp[63:32];
            16'h8000: d = {16'b0, m_pre};
            16'hBFF8: d = m_mtime[31:0];
            16'hBFFC: d = m_mtime[63:32];
            default: begin d = '0; e = 1'b1; end
        endcase
    endfunction

    logic [63:0] nx_mtime;
    int unsigned nx_pcnt;
    logic        nx_tick;
    logic [31:0] cur, upd;
    logic        cur_e;

    // Model: advance the timer one clock and apply a completed write.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mtime = '0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip  = 1'b0;
            m_pre   = '0;
            m_pcnt  = 0;
            m_mtip  = 1'b0;
        end else begin
            nx_tick  = (m_pcnt == 32'(m_pre));
            nx_pcnt  = nx_tick ? 0 : m_pcnt + 1;
            nx_mtime = nx_tick ? m_mtime + 64'd1 : m_mtime;
            m_mtip   = (m_mtime >= m_cmp);
            if (exp_ready && pwrite) begin
                mread(paddr, cur, cur_e);
                upd = merge(cur, pwdata, pstrb);
                case ({paddr[15:2], 2'b00})
                    16'h0000: m_msip = upd[0];
                    16'h4000: m_cmp[31:0] = upd;
                    16'h4004: m_cmp[63:32] = upd;
                    16'h8000: begin m_pre = upd[15:0]; nx_pcnt = 0; end
                    16'hBFF8: nx_mtime = {m_mtime[63:32], upd};
                    16'hBFFC: nx_mtime = {upd, m_mtime[31:0]};
                    default: ;
                endcase
            end
            m_pcnt  = nx_pcnt;
            m_mtime = nx_mtime;
        end
    end

    logic [31:0] c_d;
    logic        c_e;

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        chk("pready", 64'(in_pready), 64'(exp_ready));
        chk("mtip", 64'(mtip), 64'(m_mtip));
        chk("msip", 64'(msip), 64'(m_msip));
        if (exp_ready) begin
            mread(paddr, c_d, c_e);
            chk("prdata", 64'(in_prdata), 64'(c_d));
            chk("pslverr", 64'(in_pslverr), 64'(c_e));
        end else begin
            chk("prdata_idle", 64'(in_prdata), 64'd0);
            chk("pslverr_idle", 64'(in_pslverr), 64'd0);
        end
    end

    // One complete APB transfer; returns the data and error seen in the completing cycle.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        pprot = 3'($urandom);
        @(posedge clock); #1;
        penable = 1'b1;
        rd = '0; err = 1'b0;
        for (int k = 0; k <= int'(WAIT); k++) begin
            exp_ready = (k == int'(WAIT));
            @(negedge clock);
            rd  = in_prdata;
            err = in_pslverr;
            @(posedge clock); #1;
        end
        exp_ready = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; logic e;
        xfer(1'b1, a, d, 4'hF, r, e);
    endtask

    task automatic rd32(input logic [31:0] a, output logic [31:0] r);
        logic e;
        xfer(1'b0, a, 32'h0, 4'h0, r, e);
    endtask

    logic [31:0] rv;
    logic        re;
    logic        seen;
    logic [15:0] o;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mtip", 64'(mtip), 64'd0);
        chk("rst_msip", 64'(msip), 64'd0);
        chk("rst_pready", 64'(in_pready), 64'd0);

        rd32(32'h0000_4004, rv); chk("rst_cmp_hi", 64'(rv), 64'hFFFF_FFFF);
        rd32(32'h0000_BFFC, rv); chk("rst_mtime_hi", 64'(rv), 64'd0);

        wr32(32'h0000_0000, 32'h3);
        rd32(32'h0000_0000, rv); chk("msip_read", 64'(rv), 64'd1);
        xfer(1'b1, 32'h0000_0000, 32'h0, 4'h0, rv, re);
        rd32(32'h0000_0000, rv); chk("strb0_noop", 64'(rv), 64'd1);

        wr32(32'h0000_8000, 32'h3);
        wr32(32'h0000_BFFC, 32'h0);
        wr32(32'h0000_BFF8, 32'h0);
        repeat (40) @(posedge clock);
        rd32(32'h0000_BFF8, rv); chk_range("prescale3_count", rv, 9, 12);

        wr32(32'h0000_8000, 32'd20);
        wr32(32'h0000_BFFC, 32'h0);
        wr32(32'h0000_BFF8, 32'hFFFF_FFFF);
        repeat (16) @(posedge clock);
        rd32(32'h0000_BFFC, rv); chk("carry_hi", 64'(rv), 64'd1);
        rd32(32'h0000_BFF8, rv); chk("carry_lo", 64'(rv), 64'd0);

        wr32(32'h0000_8000, 32'h0);
        wr32(32'h0000_BFF8, 32'h100);
        wr32(32'h0000_8000, 32'hFFFF);
        rd32(32'h0000_BFF8, rv); chk("write_beats_tick", 64'(rv), 64'h105);

        wr32(32'h0000_BFF8, 32'h1E);
        wr32(32'h0000_4004, 32'h0);
        wr32(32'h0000_4000, 32'h20);
        wr32(32'h0000_8000, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = mtip;
        end
        chk("mtip_rise", 64'(seen), 64'd1);
        wr32(32'h0000_4004, 32'hFFFF_FFFF);
        repeat (2) @(negedge clock);
        chk("mtip_clear", 64'(mtip), 64'd0);

        xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, rv, re);
        chk("unmapped_err", 64'(re), 64'd1);
        chk("unmapped_data", 64'(rv), 64'd0);
        wr32(32'h0000_4000, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h0000_4000, 32'hAABB_CCDD, 4'b0001, rv, re);
        rd32(32'h0000_4000, rv); chk("strb_merge", 64'(rv), 64'hFFFF_FFDD);

        // Deselect mid-access: nothing may be written.
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge clock); #1 penable = 1'b1;
        @(posedge clock); #1 psel = 1'b0; penable = 1'b0;
        rd32(32'h0000_0000, rv); chk("abort_no_write", 64'(rv), 64'd1);

        // Reset in the middle of an access.
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4004; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge clock); #1 penable = 1'b1;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 psel = 1'b0; penable = 1'b0; reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_msip", 64'(msip), 64'd0);
        rd32(32'h0000_4004, rv); chk("rst_mid_cmp_hi", 64'(rv), 64'hFFFF_FFFF);

        // Randomized traffic over mapped and unmapped offsets.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 7))
                0: o = 16'h0000;
                1: o = 16'h4000;
                2: o = 16'h4004;
                3: o = 16'h8000;
                4: o = 16'hBFF8;
                5: o = 16'hBFFC;
                6: o = 16'h1000;
                default: o = 16'($urandom);
            endcase
            o[1:0] = 2'($urandom);
            if (o == 16'h8000 || (o & 16'hFFFC) == 16'h8000)
                xfer(1'($urandom), {16'($urandom), o}, 32'($urandom_range(0, 7)), 4'($urandom), rv, re);
            else if ((o & 16'hFFFC) == 16'hBFF8 || (o & 16'hFFFC) == 16'h4000)
                xfer(1'($urandom), {16'($urandom), o}, 32'($urandom_range(0, 64)), 4'($urandom), rv, re);
            else
                xfer(1'($urandom), {16'($urandom), o}, $urandom, 4'($urandom), rv, re);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clock);
        end

        repeat (4) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
